// File: rtl/dot_product_scheduler_pkg.sv
// Shared definitions for the dot-product scheduler: FSM state encodings,
// index-width helper and the saturating Q-rescale used on engine results.
package dp_sched_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ISSUE   = 2'd1;
  localparam state_t ST_WAIT    = 2'd2;
  localparam state_t ST_RESPOND = 2'd3;

  // Width of an index able to address n requesters (never below one bit).
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Arithmetic right shift by frac, then clamp into the signed w-bit range.
  // Works on a 64-bit container so the caller just truncates to w bits.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] val,
                                                   input int w,
                                                   input int frac);
    logic signed [63:0] shifted;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    shifted = val >>> frac;
    max_v   = (64'sd1 <<< (w - 1)) - 64'sd1;
    min_v   = -(64'sd1 <<< (w - 1));
    if (shifted > max_v) begin
      return max_v;
    end
    if (shifted < min_v) begin
      return min_v;
    end
    return shifted;
  endfunction

endpackage

// File: rtl/dot_product_scheduler_if.sv
// Bundle of requester-side and engine-side signals around the scheduler.
// slave = scheduler view, master = requesters plus engine view.
interface dot_product_scheduler_if #(
  parameter int W = 16,
  parameter int N = 4
);
  import dp_sched_pkg::*;

  localparam int IDX_W = idx_w(N);

  logic [N-1:0]       req;
  logic [N*4*W-1:0]   req_a;
  logic [N-1:0]       resp_v;
  logic [2*W-1:0]     resp_raw;
  logic [W-1:0]       resp_q;
  logic               busy;
  logic               eng_start;
  logic [4*W-1:0]     eng_a;
  logic [IDX_W-1:0]   eng_sel;
  logic               eng_done;
  logic [2*W-1:0]     eng_result;
  logic               err_timeout;

  modport slave (
    input  req, req_a, eng_done, eng_result,
    output resp_v, resp_raw, resp_q, busy, eng_start, eng_a, eng_sel, err_timeout
  );

  modport master (
    output req, req_a, eng_done, eng_result,
    input  resp_v, resp_raw, resp_q, busy, eng_start, eng_a, eng_sel, err_timeout
  );

endinterface

// File: rtl/dot_product_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one position after
// ptr and wraps modulo N, so the last-served requester has lowest priority.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_grant
);

  // Candidate index for each search offset, already rotated past ptr.
  logic [IDX_W-1:0] cand_idx [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      assign cand_idx[gi] = IDX_W'((int'(ptr) + gi + 1) % N);
    end
  endgenerate

  // First requesting candidate in rotated order wins; grant is its one-hot.
  always_comb begin
    grant_idx = '0;
    any_grant = 1'b0;
    grant     = '0;
    for (int k = 0; k < N; k++) begin
      if (!any_grant && req[cand_idx[k]]) begin
        grant_idx = cand_idx[k];
        any_grant = 1'b1;
      end
    end
    if (any_grant) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/dot_product_scheduler.sv
// Shares one multi-cycle dot-product engine among N requesters.
// IDLE grants round-robin and latches activations, ISSUE pulses start,
// WAIT collects the result (or gives up after TIMEOUT cycles), RESPOND
// pulses resp_v to the granted requester only.
module dot_product_scheduler
  import dp_sched_pkg::*;
#(
  parameter int W       = 16,
  parameter int N       = 4,
  parameter int FRAC    = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  dot_product_scheduler_if.slave bus
);

  localparam int IDX_W = idx_w(N);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  state_t             state_reg;
  state_t             state_next;
  logic [IDX_W-1:0]   rr_ptr_reg;
  logic [IDX_W-1:0]   eng_sel_reg;
  logic [N-1:0]       grant_oh_reg;
  logic [4*W-1:0]     eng_a_reg;
  logic [2*W-1:0]     resp_raw_reg;
  logic [W-1:0]       resp_q_reg;
  logic               err_timeout_reg;
  logic [TMR_W-1:0]   timer_reg;

  logic [N-1:0]       arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic [W-1:0]       sat_q;
  logic               timer_expired;
  logic [4*W-1:0]     act_slice [N];

  // Per-requester activation slices so the grant index can pick one directly.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slice
      assign act_slice[gi] = bus.req_a[gi*4*W +: 4*W];
    end
  endgenerate

  rr_arbiter #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (bus.req),
    .ptr       (rr_ptr_reg),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_grant (arb_any)
  );

  assign sat_q         = W'(sat_shift(64'($signed(bus.eng_result)), W, FRAC));
  assign timer_expired = (timer_reg == TMR_W'(TIMEOUT - 1));

  // Next-state decode; eng_done is only honoured in WAIT, so a done that
  // coincides with the start pulse is dropped.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (arb_any) state_next = ST_ISSUE;
      ST_ISSUE:   state_next = ST_WAIT;
      ST_WAIT:    if (bus.eng_done || timer_expired) state_next = ST_RESPOND;
      ST_RESPOND: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // State, grant latches, timeout counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      rr_ptr_reg      <= IDX_W'(N - 1);
      eng_sel_reg     <= '0;
      grant_oh_reg    <= '0;
      eng_a_reg       <= '0;
      resp_raw_reg    <= '0;
      resp_q_reg      <= '0;
      err_timeout_reg <= 1'b0;
      timer_reg       <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (arb_any) begin
            eng_a_reg    <= act_slice[arb_idx];
            eng_sel_reg  <= arb_idx;
            grant_oh_reg <= arb_grant;
          end
        end
        ST_ISSUE: begin
          timer_reg <= '0;
        end
        ST_WAIT: begin
          if (bus.eng_done) begin
            resp_raw_reg <= bus.eng_result;
            resp_q_reg   <= sat_q;
          end else if (timer_expired) begin
            resp_raw_reg    <= '0;
            resp_q_reg      <= '0;
            err_timeout_reg <= 1'b1;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        ST_RESPOND: begin
          rr_ptr_reg <= eng_sel_reg;
        end
        default: ;
      endcase
    end
  end

  // Pulses are decoded from the state so reset removes them immediately.
  assign bus.busy        = (state_reg != ST_IDLE);
  assign bus.eng_start   = (state_reg == ST_ISSUE);
  assign bus.resp_v      = (state_reg == ST_RESPOND) ? grant_oh_reg : '0;
  assign bus.eng_a       = eng_a_reg;
  assign bus.eng_sel     = eng_sel_reg;
  assign bus.resp_raw    = resp_raw_reg;
  assign bus.resp_q      = resp_q_reg;
  assign bus.err_timeout = err_timeout_reg;

endmodule

// File: tb/tb_dot_product_scheduler.sv
// Bench for dot_product_scheduler: behavioural engine with per-bank weights,
// scoreboard of expected responses in grant order.
module tb_dot_product_scheduler;
  import dp_sched_pkg::*;

  localparam int W       = 16;
  localparam int N       = 4;
  localparam int FRAC    = 8;
  localparam int TIMEOUT = 64;
  localparam int ENG_LAT = 5;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dot_product_scheduler_if #(.W(W), .N(N)) bus ();

  dot_product_scheduler #(
    .W       (W),
    .N       (N),
    .FRAC    (FRAC),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          idx;
    logic [31:0] raw;
    logic [15:0] q;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int resp_cnt = 0;
  int last_resp_cyc = 0;
  int starts   = 0;

  // engine model state
  logic        eng_pending = 1'b0;
  int          eng_cnt     = 0;
  logic        eng_hang    = 1'b0;
  logic        eng_force_en = 1'b0;
  logic [31:0] eng_force_val = '0;
  logic [63:0] eng_a_lat   = '0;
  int          eng_sel_lat = 0;
  logic        hold_req    = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Engine weights: every tap of bank b is (b+1).0 in Q8.
  function automatic logic [31:0] dot_ref(input logic [63:0] a, input int bank);
    int s;
    s = 0;
    for (int k = 0; k < 4; k++) begin
      s += int'($signed(a[k*16 +: 16])) * (bank + 1) * 256;
    end
    return 32'(s);
  endfunction

  function automatic logic [15:0] sat_ref(input logic [31:0] raw);
    logic signed [31:0] sh;
    sh = $signed(raw) >>> FRAC;
    if (sh > 32767) return 16'h7FFF;
    if (sh < -32768) return 16'h8000;
    return sh[15:0];
  endfunction

  function automatic logic [63:0] mk_act(input int seed);
    logic [63:0] v;
    int t;
    for (int k = 0; k < 4; k++) begin
      t = (seed + k + 1) * 32;
      if (k == 2) t = -t;
      v[k*16 +: 16] = 16'(t);
    end
    return v;
  endfunction

  task automatic set_act(input int i, input logic [63:0] v);
    bus.req_a[i*64 +: 64] = v;
  endtask

  task automatic push_exp(input int idx, input logic [31:0] raw, input logic [15:0] q);
    exp_t e;
    e.idx = idx;
    e.raw = raw;
    e.q   = q;
    sb.push_back(e);
  endtask

  // One clock: engine model, response monitor, requester release.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    bus.eng_done = 1'b0;
    if (rst) begin
      eng_pending = 1'b0;
    end else if (bus.eng_start) begin
      starts++;
      eng_pending = 1'b1;
      eng_cnt     = ENG_LAT;
      eng_a_lat   = bus.eng_a;
      eng_sel_lat = int'(bus.eng_sel);
    end else if (eng_pending && !eng_hang) begin
      if (eng_cnt == 0) begin
        bus.eng_done   = 1'b1;
        bus.eng_result = eng_force_en ? eng_force_val : dot_ref(eng_a_lat, eng_sel_lat);
        eng_pending    = 1'b0;
      end else begin
        eng_cnt--;
      end
    end
    if (bus.resp_v != '0) begin
      resp_cnt++;
      last_resp_cyc = cyc;
      check_eq("resp_v_onehot", 64'($countones(bus.resp_v)), 64'd1);
      if (sb.size() == 0) begin
        check_eq("resp_unexpected", 64'(bus.resp_v), 64'd0);
      end else begin
        e = sb.pop_front();
        $display("txn %0d: req=%0d resp_v=%b raw=0x%08h q=0x%04h err=%0b",
                 resp_cnt, e.idx, bus.resp_v, bus.resp_raw, bus.resp_q, bus.err_timeout);
        check_eq("resp_v", 64'(bus.resp_v), 64'(1 << e.idx));
        check_eq("resp_raw", 64'(bus.resp_raw), 64'(e.raw));
        check_eq("resp_q", 64'(bus.resp_q), 64'(e.q));
      end
      if (!hold_req) bus.req = bus.req & ~bus.resp_v;
    end
  endtask

  task automatic wait_resps(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (resp_cnt < target && n < budget) begin
      step();
      n++;
    end
    check_eq({tag, "_in_budget"}, 64'(resp_cnt >= target), 64'd1);
  endtask

  initial begin
    logic [63:0] orig;
    logic [31:0] sat_raw [4];
    logic [15:0] sat_q   [4];
    int base;
    int req_cyc;
    int starts0;
    int n;

    rst            = 1'b1;
    bus.req        = '0;
    bus.req_a      = '0;
    bus.eng_done   = 1'b0;
    bus.eng_result = '0;
    repeat (3) step();
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_eng_start", 64'(bus.eng_start), 64'd0);
    check_eq("rst_resp_v", 64'(bus.resp_v), 64'd0);
    check_eq("rst_err", 64'(bus.err_timeout), 64'd0);
    check_eq("rst_eng_a", 64'(bus.eng_a), 64'd0);
    check_eq("rst_eng_sel", 64'(bus.eng_sel), 64'd0);
    check_eq("rst_resp_raw", 64'(bus.resp_raw), 64'd0);
    check_eq("rst_resp_q", 64'(bus.resp_q), 64'd0);
    rst = 1'b0;
    step();

    // All four requesting continuously: grants 0,1,2,3,0.
    for (int i = 0; i < N; i++) set_act(i, mk_act(i * 3));
    push_exp(0, dot_ref(mk_act(0), 0), sat_ref(dot_ref(mk_act(0), 0)));
    push_exp(1, dot_ref(mk_act(3), 1), sat_ref(dot_ref(mk_act(3), 1)));
    push_exp(2, dot_ref(mk_act(6), 2), sat_ref(dot_ref(mk_act(6), 2)));
    push_exp(3, dot_ref(mk_act(9), 3), sat_ref(dot_ref(mk_act(9), 3)));
    push_exp(0, dot_ref(mk_act(0), 0), sat_ref(dot_ref(mk_act(0), 0)));
    hold_req = 1'b1;
    base = resp_cnt;
    bus.req = 4'b1111;
    n = 0;
    while (resp_cnt < base + 5 && n < 200) begin
      step();
      n++;
    end
    bus.req  = '0;
    hold_req = 1'b0;
    check_eq("rr_in_budget", 64'(resp_cnt - base), 64'd5);
    step();
    step();
    check_eq("rr_idle_busy", 64'(bus.busy), 64'd0);
    check_eq("rr_sb_empty", 64'(sb.size()), 64'd0);

    // Single request: a = 1,2,3,4 in Q8, bank 0 weights 1.0.
    set_act(0, {16'h0400, 16'h0300, 16'h0200, 16'h0100});
    push_exp(0, 32'h000A0000, 16'h0A00);
    starts0 = starts;
    base    = resp_cnt;
    bus.req = 4'b0001;
    req_cyc = cyc;
    wait_resps(base + 1, 50, "single");
    check_eq("single_latency", 64'(last_resp_cyc - req_cyc), 64'd8);
    check_eq("single_starts", 64'(starts - starts0), 64'd1);
    check_eq("single_eng_sel", 64'(bus.eng_sel), 64'd0);
    check_eq("single_raw_held", 64'(bus.resp_raw), 64'h000A0000);
    step();

    // Saturation corners through the Q rescale.
    sat_raw[0] = 32'h7FFF0000; sat_q[0] = 16'h7FFF;
    sat_raw[1] = 32'h80000000; sat_q[1] = 16'h8000;
    sat_raw[2] = 32'hFFFFFF00; sat_q[2] = 16'hFFFF;
    sat_raw[3] = 32'h01000000; sat_q[3] = 16'h7FFF;
    eng_force_en = 1'b1;
    for (int t = 0; t < 4; t++) begin
      eng_force_val = sat_raw[t];
      set_act(1, mk_act(t));
      push_exp(1, sat_raw[t], sat_q[t]);
      base    = resp_cnt;
      bus.req = 4'b0010;
      wait_resps(base + 1, 50, "sat");
      step();
    end
    eng_force_en = 1'b0;

    // Timeout: engine hangs, then normal service resumes with flag sticky.
    check_eq("pre_timeout_err", 64'(bus.err_timeout), 64'd0);
    eng_hang = 1'b1;
    set_act(2, mk_act(5));
    push_exp(2, 32'h0, 16'h0);
    base    = resp_cnt;
    bus.req = 4'b0100;
    wait_resps(base + 1, TIMEOUT + 30, "timeout");
    check_eq("timeout_err", 64'(bus.err_timeout), 64'd1);
    eng_hang = 1'b0;
    step();
    set_act(3, mk_act(7));
    push_exp(3, dot_ref(mk_act(7), 3), sat_ref(dot_ref(mk_act(7), 3)));
    base    = resp_cnt;
    bus.req = 4'b1000;
    wait_resps(base + 1, 50, "post_timeout");
    check_eq("post_timeout_err", 64'(bus.err_timeout), 64'd1);
    step();

    // Reset while requester 2 is in WAIT: no response for it.
    set_act(2, mk_act(2));
    bus.req = 4'b0100;
    repeat (3) step();
    check_eq("midwait_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("arst_busy", 64'(bus.busy), 64'd0);
    check_eq("arst_resp_v", 64'(bus.resp_v), 64'd0);
    check_eq("arst_err", 64'(bus.err_timeout), 64'd0);
    bus.req = '0;
    step();
    step();
    rst = 1'b0;
    step();
    set_act(0, mk_act(1));
    set_act(2, mk_act(4));
    push_exp(0, dot_ref(mk_act(1), 0), sat_ref(dot_ref(mk_act(1), 0)));
    push_exp(2, dot_ref(mk_act(4), 2), sat_ref(dot_ref(mk_act(4), 2)));
    base    = resp_cnt;
    bus.req = 4'b0101;
    wait_resps(base + 2, 100, "post_reset");
    step();

    // Late change of req_a while in WAIT must not affect the operation.
    orig = mk_act(8);
    set_act(2, orig);
    push_exp(2, dot_ref(orig, 2), sat_ref(dot_ref(orig, 2)));
    base    = resp_cnt;
    bus.req = 4'b0100;
    repeat (3) step();
    set_act(2, mk_act(11));
    step();
    check_eq("late_eng_a", bus.eng_a, orig);
    wait_resps(base + 1, 50, "late");

    repeat (4) step();
    check_eq("final_sb_empty", 64'(sb.size()), 64'd0);
    check_eq("final_busy", 64'(bus.busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dot_product_scheduler.md
Name: dot_product_scheduler

Overview:
Round-robin scheduler sharing one multi-cycle dot-product engine among N requesters (one per output channel / conv tap group). Latches the winning requester's four activations, selects its weight bank, pulses start, waits for the engine's done, then returns the raw and Q-rescaled results to that requester only. Sits between per-channel cache/activation logic and the single dot-product engine.

Parameters:
W, 16, activation/weight width; engine result is 2W.
N, 4, number of requesters (2..8).
FRAC, 8, fractional bits removed when rescaling the 2W result to W (arithmetic right shift).
TIMEOUT, 64, max cycles in WAIT before the engine is declared hung.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
req  in  N  per-requester request, level; held until its resp_v
req_a  in  N*4*W  per-requester activations d0..d3, requester i at [i*4W +: 4W], d0 in the LSBs
resp_v  out  N  one-hot, 1-cycle pulse to the served requester
resp_raw  out  2W  raw engine result, valid with resp_v
resp_q  out  W  saturated (resp_raw >>> FRAC), valid with resp_v
busy  out  1  high in every state except IDLE
eng_start  out  1  1-cycle start pulse to engine
eng_a  out  4W  latched activations for engine
eng_sel  out  clog2(N)  weight-bank index = granted requester
eng_done  in  1  engine result-valid pulse
eng_result  in  2W  engine result
err_timeout  out  1  sticky hang flag

Behaviour:
- Reset (async): state=IDLE, rr_ptr=N-1, and resp_v, eng_start, busy, err_timeout = 0. eng_a, eng_sel, resp_raw and resp_q = 0.
- States: IDLE, ISSUE, WAIT, RESPOND.
- IDLE: if any req is set, grant the first set bit searching from rr_ptr+1 upward, modulo N. Latch eng_a from that slice and eng_sel=grant. Go to ISSUE. Otherwise stay.
- ISSUE: eng_start=1 for exactly this cycle. Clear the timeout counter. Go to WAIT.
- WAIT: on eng_done, register resp_raw=eng_result and resp_q=sat(eng_result>>>FRAC), then go to RESPOND.
  - eng_done in the same cycle as eng_start (ISSUE) is ignored.
  - If the counter reaches TIMEOUT without eng_done: set err_timeout and go to RESPOND with resp_raw=0 and resp_q=0.
- RESPOND: resp_v[grant]=1 for one cycle. rr_ptr=grant. Go to IDLE.
- Latency: from IDLE seeing req to resp_v = 3 + engine latency cycles. Minimum requester turnaround is 4 cycles plus engine latency.
- Saturation: shifted value clamps to [-2^(W-1), 2^(W-1)-1]. For W=16 that is -32768..32767.
- Fairness: after serving i, requester i has lowest priority. With all N requesting continuously, grant order is 0,1,...,N-1,0,...
- A requester must hold req high until its resp_v. req dropped while granted: the transaction still completes and resp_v still pulses.
- Requester activations are sampled only in the IDLE grant cycle; later changes to req_a do not affect the in-flight operation.
- err_timeout clears only on rst. Scheduling continues after a timeout.
- Reset mid-operation (any state): return immediately to IDLE with outputs at reset values. No resp_v is issued for the aborted request.
- Engine contract: an eng_start pulse always restarts the engine; the engine emits exactly one eng_done per start.

Decomposition:
- Shared package dp_sched_pkg: state enum, helper functions clog2-based IDX_W and sat_shift(2W->W, FRAC).
- One sub-module rr_arbiter (N-bit req, pointer in, one-hot grant and index out, combinational priority rotate). The FSM, latches and timeout counter stay in the top.

Test Plan:
- Single request: req=0001, a0..a3=1,2,3,4 (Q8), engine model with weights 1.0 returns 10.0 (raw 0x000A0000) after 5 cycles. Expect eng_sel=0, one eng_start pulse, resp_v=0001 exactly 8 cycles after req, resp_q=0x0A00.
- All four requesting continuously: expect grant order 0,1,2,3,0 and exactly one resp_v bit per transaction, never two.
- Saturation: engine returns raw 0x7FFF0000 → resp_q=0x7FFF. Raw 0x80000000 → resp_q=0x8000. Raw 0xFFFFFF00 → resp_q=0xFFFF (-1 LSB).
- Timeout: engine never asserts done. After 64 WAIT cycles expect err_timeout=1, resp_v pulse with resp_raw=0, then the next request is served normally with err_timeout still 1.
- Reset mid-WAIT: assert rst during WAIT for request 2. Expect busy=0 and resp_v=0 asynchronously. After release, rr_ptr=3 so requester 0 wins if 0 and 2 both request.
- Late req change: modify req_a[2] during WAIT. Expect eng_a unchanged and the result computed from the original values.
